// File: rtl/decoder_pkg.sv
// Shared types and the reference decode function for the N-to-2^N decoder family.
// The scan sequencer in the top is only built when DECODER_SCAN_EN is defined.
package decoder_pkg;

    localparam int MAX_N     = 8;
    localparam int MAX_OUT_W = 2 ** MAX_N;

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'b00,
        MODE_THERMO  = 2'b01,
        MODE_ONECOLD = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Returns the full-width word; callers keep the low OUT_W bits. Code 11 decodes as one-hot.
    function automatic logic [MAX_OUT_W-1:0] decode(input int unsigned addr, input logic [1:0] mode);
        logic [MAX_OUT_W-1:0] w;
        for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
            case (mode)
                MODE_THERMO:  w[i] = (i <= addr);
                MODE_ONECOLD: w[i] = (i != addr);
                default:      w[i] = (i == addr);
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_nto2n_comb.sv
// Purely combinational decode of an N-bit address into a 2^N-bit word.
// Used by decoder_nto2n_seq (whose scan sequencer is gated by DECODER_SCAN_EN).
module decoder_nto2n_comb
    import decoder_pkg::*;
#(
    parameter int N = 3,
    localparam int OUT_W = 2 ** N
) (
    input  logic [N-1:0]     a_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] y_o
);

    logic [MAX_OUT_W-1:0] word;
    logic                 unused_hi;

    assign word      = decode(32'(a_i), mode_i);
    assign y_o       = word[OUT_W-1:0];
    assign unused_hi = ^word;

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N decoder with valid/ready in and out, plus an address-sweep sequencer.
// Define DECODER_SCAN_EN to build the scan FSM; otherwise scan_start/dwell are ignored and busy is 0.
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = 2 ** N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       a,
    input  logic [1:0]         mode,
    input  logic               scan_start,
    input  logic [DWELL_W-1:0] dwell,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   y,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // Handshake: a beat moves when valid && ready are both high on a rising edge of clk.
    logic [OUT_W-1:0] y_q;
    logic             out_valid_q;
    logic             out_free;
    logic             scan_load;
    logic             load;
    logic [N-1:0]     dec_addr;
    logic [1:0]       dec_mode;
    logic [OUT_W-1:0] dec_y;

    assign out_free = !out_valid_q || out_ready;
    assign load     = (in_valid && in_ready) || scan_load;

`ifdef DECODER_SCAN_EN
    state_e             state_q, state_d;
    logic [N-1:0]       addr_q, addr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         smode_q, smode_d;
    logic               last_addr;

    assign last_addr = (addr_q == {N{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            smode_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            smode_q <= smode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        smode_d = smode_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = EMIT;
                    addr_d  = '0;
                    cnt_d   = '0;
                    dwell_d = dwell;
                    smode_d = mode;
                end
            end
            EMIT: begin
                if (out_free) begin
                    if (dwell_q != '0) begin
                        state_d = HOLD;
                        cnt_d   = dwell_q;
                    end else if (last_addr) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + N'(1);
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q - DWELL_W'(1);
                if (cnt_q == DWELL_W'(1)) begin
                    if (last_addr) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EMIT;
                        addr_d  = addr_q + N'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While a sweep runs, the decoder sees the scan address and the mode latched at start.
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == IDLE) && !scan_start && out_free;
        scan_load = (state_q == EMIT) && out_free;
        dec_addr  = (state_q == IDLE) ? a : addr_q;
        dec_mode  = (state_q == IDLE) ? mode : smode_q;
        dbg_state = state_q;
    end
`else
    logic unused_scan;

    assign unused_scan = ^{scan_start, dwell};
    assign busy        = 1'b0;
    assign in_ready    = out_free;
    assign scan_load   = 1'b0;
    assign dec_addr    = a;
    assign dec_mode    = mode;
    assign dbg_state   = IDLE;
`endif

    decoder_nto2n_comb #(.N(N)) u_comb (
        .a_i    (dec_addr),
        .mode_i (dec_mode),
        .y_o    (dec_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (load) begin
            y_q         <= dec_y;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed plus randomized bench for decoder_nto2n_seq (N=3); scan checks depend on DECODER_SCAN_EN.
module tb_decoder_nto2n_seq;

    localparam int N       = 3;
    localparam int OUT_W   = 8;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       a;
    logic [1:0]         mode;
    logic               scan_start;
    logic [DWELL_W-1:0] dwell;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   y;
    logic               busy;
    logic [1:0]         dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q[$];

    decoder_nto2n_seq #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .mode       (mode),
        .scan_start (scan_start),
        .dwell      (dwell),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference decode from arithmetic on powers of two.
    function automatic logic [OUT_W-1:0] model(input int addr, input logic [1:0] m);
        int unsigned one_hot;
        one_hot = 32'd1 << addr;
        case (m)
            2'b01:   return OUT_W'((one_hot << 1) - 1);
            2'b10:   return OUT_W'(~one_hot);
            default: return OUT_W'(one_hot);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, confirm it is accepted, then confirm the registered result.
    task automatic send(input logic [N-1:0] addr, input logic [1:0] m, input logic [OUT_W-1:0] exp_y);
        in_valid = 1'b1;
        a        = addr;
        mode     = m;
        #1 check("send_in_ready", in_ready, 1);
        tick();
        check("send_y", y, exp_y);
        check("send_out_valid", out_valid, 1);
    endtask

    // Sweep with an always-ready consumer; beat k lands after edge 1+k*(d+1), busy lasts OUT_W*(d+1) edges.
    task automatic run_scan(input int d, input logic [1:0] m, input int abort_at);
        int total;
        logic exp_v;
        logic [OUT_W-1:0] w;
        total = OUT_W * (d + 1);
        exp_q.delete();
        for (int k = 0; k < OUT_W; k++) exp_q.push_back(model(k, m));
        scan_start = 1'b1;
        dwell      = DWELL_W'(d);
        mode       = m;
        in_valid   = 1'b1;
        a          = N'($urandom_range(0, OUT_W - 1));
        out_ready  = 1'b1;
        #1 check("scan_collide_in_ready", in_ready, 0);
        tick();
        scan_start = 1'b0;
        check("scan_busy_rise", busy, 1);
        for (int j = 1; j <= total; j++) begin
            mode       = 2'($urandom_range(0, 3));
            a          = N'($urandom_range(0, OUT_W - 1));
            dwell      = DWELL_W'($urandom_range(0, 5));
            scan_start = (j == 5);
            if (j == total) in_valid = 1'b0;
            #1 check("scan_in_ready", in_ready, 0);
            tick();
            exp_v = ((j - 1) % (d + 1) == 0);
            check("scan_out_valid", out_valid, exp_v);
            if (exp_v) begin
                if (exp_q.size() == 0) begin
                    check("scan_extra_beat", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("scan_y", y, w);
                end
            end
            check("scan_busy", busy, (j < total));
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_y", y, 0);
                check("abort_out_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                break;
            end
        end
        in_valid   = 1'b0;
        scan_start = 1'b0;
        if (abort_at < 0) check("scan_all_beats", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [1:0]   rm;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        mode       = 2'b00;
        scan_start = 1'b0;
        dwell      = '0;
        out_ready  = 1'b1;
        #1;
        check("reset_y", y, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Back-to-back one-hot sweep at full throughput.
        for (int i = 0; i < OUT_W; i++) send(N'(i), 2'b00, OUT_W'(1 << i));

        send(3'd5, 2'b01, 8'h3F);
        send(3'd2, 2'b10, 8'hFB);
        send(3'd4, 2'b11, 8'h10);
        send(3'd0, 2'b01, 8'h01);
        send(3'd7, 2'b01, 8'hFF);

        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom_range(0, OUT_W - 1));
            rm = 2'($urandom_range(0, 3));
            send(ra, rm, model(int'(ra), rm));
        end

        // Drain, then stall the consumer behind a single beat.
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", out_valid, 0);
        out_ready = 1'b0;
        send(3'd6, 2'b00, 8'h40);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = N'($urandom_range(0, OUT_W - 1));
            mode     = 2'($urandom_range(0, 3));
            #1 check("stall_in_ready", in_ready, 0);
            tick();
            check("stall_y", y, 8'h40);
            check("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        send(3'd1, 2'b00, 8'h02);
        in_valid = 1'b0;
        tick();

`ifdef DECODER_SCAN_EN
        run_scan(2, 2'b00, -1);
        tick();
        run_scan(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1);
        tick();
        run_scan(2, 2'b00, 10);
        #2 rst_n = 1'b1;
        tick();
        run_scan(0, 2'b00, -1);
        tick();
        send(3'd3, 2'b10, 8'hF7);
        in_valid = 1'b0;
        tick();
`else
        check("off_drained", out_valid, 0);
        scan_start = 1'b1;
        dwell      = DWELL_W'($urandom_range(0, 5));
        #1 check("off_in_ready", in_ready, 1);
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("off_out_valid", out_valid, 0);
            check("off_busy", busy, 0);
            tick();
        end
        send(3'd3, 2'b10, 8'hF7);
        in_valid = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
